oq_pifo_ingress_tagger: RTL

Upstream companion of the PIFO output queue: drives the queue's write side. Takes a plain AXI4-Stream packet from the output-port lookup / arbiter and produces the queue's ingress stream with sideband `tpifo`, `buffer_wr_en` and `pifo_insert_en`. Derives the root-level PIFO rank word from a `tuser` field. Performs tail-drop admission against the queue's almost-full flag, decided once per packet at the first beat.

---
 rtl/oq_pifo_ingress_tagger.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/oq_pifo_ingress_tagger.sv
// Ingress tagger for the PIFO output queue. It derives the root rank word from tuser,
// makes a tail-drop decision at the first beat of each packet, and registers one output beat.
module oq_pifo_ingress_tagger #(
  parameter int          RANK_LSB     = 32,
  parameter logic [18:0] DEFAULT_RANK = 19'd100
) (
  input  logic         axis_aclk,
  input  logic         axis_reset,
  input  logic [255:0] s_axis_tdata,
  input  logic [31:0]  s_axis_tkeep,
  input  logic [127:0] s_axis_tuser,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic [255:0] m_axis_tdata,
  output logic [31:0]  m_axis_tkeep,
  output logic [127:0] m_axis_tuser,
  output logic [31:0]  m_axis_tpifo,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  output logic         m_axis_buffer_wr_en,
  output logic         m_axis_pifo_insert_en,
  input  logic         m_axis_tready,
  input  logic         oq_almost_full,
  output logic [31:0]  pkt_count,
  output logic [31:0]  drop_count
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  // A zero rank field means "no rank supplied" and falls back to the default.
  function automatic logic [31:0] rank_word(input logic [18:0] field);
    logic [18:0] r;
    r = (field == 19'd0) ? DEFAULT_RANK : field;
    return {1'b1, r, 12'b0};
  endfunction

  state_t         state_q, state_d;
  logic [255:0]   tdata_q, tdata_d;
  logic [31:0]    tkeep_q, tkeep_d;
  logic [127:0]   tuser_q, tuser_d;
  logic [31:0]    tpifo_q, tpifo_d;
  logic           tlast_q, tlast_d;
  logic           tvalid_q, tvalid_d;
  logic           insert_q, insert_d;
  logic [31:0]    pkt_count_q, pkt_count_d;
  logic [31:0]    drop_count_q, drop_count_d;

  logic           in_acc;
  logic           out_cons;
  logic           first_fwd;
  logic           first_drop;
  logic           load;

  assign in_acc     = s_axis_tvalid && s_axis_tready;
  assign out_cons   = tvalid_q && m_axis_tready;
  assign first_fwd  = in_acc && (state_q == IDLE) && !oq_almost_full;
  assign first_drop = in_acc && (state_q == IDLE) && oq_almost_full;
  assign load       = first_fwd || (in_acc && (state_q == FWD));

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_acc && !s_axis_tlast) begin
          state_d = oq_almost_full ? DROP : FWD;
        end
      end
      FWD, DROP: begin
        if (in_acc && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // DROP sinks beats unconditionally so a dropped packet never stalls upstream.
  always_comb begin
    s_axis_tready = !axis_reset &&
                    ((state_q == DROP) || !tvalid_q || m_axis_tready);
  end

  always_comb begin
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tuser_d      = tuser_q;
    tpifo_d      = tpifo_q;
    tlast_d      = tlast_q;
    tvalid_d     = tvalid_q;
    insert_d     = insert_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;

    if (out_cons) begin
      tvalid_d = 1'b0;
    end
    // A load in the same cycle as a consume overrides the clear, giving no bubble.
    if (load) begin
      tdata_d  = s_axis_tdata;
      tkeep_d  = s_axis_tkeep;
      tuser_d  = s_axis_tuser;
      tlast_d  = s_axis_tlast;
      tvalid_d = 1'b1;
      insert_d = first_fwd;
      if (first_fwd) begin
        tpifo_d = rank_word(s_axis_tuser[RANK_LSB +: 19]);
      end
    end

    if (first_fwd) begin
      pkt_count_d = sat_inc(pkt_count_q);
    end
    if (first_drop) begin
      drop_count_d = sat_inc(drop_count_q);
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tuser_q      <= '0;
      tpifo_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      insert_q     <= 1'b0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tuser_q      <= tuser_d;
      tpifo_q      <= tpifo_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
      insert_q     <= insert_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign m_axis_tdata          = tdata_q;
  assign m_axis_tkeep          = tkeep_q;
  assign m_axis_tuser          = tuser_q;
  assign m_axis_tpifo          = tpifo_q;
  assign m_axis_tvalid         = tvalid_q;
  assign m_axis_tlast          = tlast_q;
  assign m_axis_buffer_wr_en   = tvalid_q;
  assign m_axis_pifo_insert_en = tvalid_q && insert_q;
  assign pkt_count             = pkt_count_q;
  assign drop_count            = drop_count_q;

endmodule
